snake_body_writer: RTL and testbench

- Game-side owner of the snake body buffer, a circular cell-index memory. It is the writer end of the body FIFO that the VGA renderer reads.
- On each game tick it computes the new head cell from the current direction and scans the body for self-collision. It then pushes the head and pops the tail, except on a growth step, where the tail is kept.
- It exposes a random-access read port so the renderer can fetch body cells by position.

---
 rtl/snake_body_writer.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_snake_body_writer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_writer.sv
// Snake body buffer writer: owns the circular cell-index RAM, steps the head each game tick,
// checks self/wall collision and serves a random-access read port. Define SNAKE_WRAP_EN to wrap walls.
module snake_body_writer #(
    parameter int unsigned GRID_W    = 64,
    parameter int unsigned GRID_H    = 48,
    parameter int unsigned IDX_W     = 12,
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned PTR_W     = 8,
    parameter int unsigned INIT_LEN  = 4,
    parameter int unsigned START_COL = 32,
    parameter int unsigned START_ROW = 24
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iTick,
    input  logic [1:0]       iDir,
    input  logic             iGrow,
    input  logic [PTR_W-1:0] iRd_Idx,
    output logic [IDX_W-1:0] oRd_Data,
    output logic             oRd_Valid,
    output logic [PTR_W:0]   oLength,
    output logic [IDX_W-1:0] oHead,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDead,
    output logic             oOverrun
);

    localparam int unsigned COL_W = $clog2(GRID_W);
    localparam int unsigned ROW_W = $clog2(GRID_H);

    localparam logic [IDX_W-1:0] START_IDX = IDX_W'(START_ROW * GRID_W + START_COL);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(START_ROW * GRID_W + START_COL - (INIT_LEN - 1));
    localparam logic [PTR_W:0]   LEN_INIT  = (PTR_W + 1)'(INIT_LEN);
    localparam logic [PTR_W:0]   LEN_MAX   = (PTR_W + 1)'(MAX_LEN);

`ifdef SNAKE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [2:0] StInit   = 3'd0;
    localparam logic [2:0] StIdle   = 3'd1;
    localparam logic [2:0] StCalc   = 3'd2;
    localparam logic [2:0] StScan   = 3'd3;
    localparam logic [2:0] StCommit = 3'd4;
    localparam logic [2:0] StDead   = 3'd5;

    localparam logic [1:0] DirDown  = 2'b00;
    localparam logic [1:0] DirRight = 2'b01;
    localparam logic [1:0] DirLeft  = 2'b10;
    localparam logic [1:0] DirUp    = 2'b11;

    logic [IDX_W-1:0] mem_q [MAX_LEN];

    logic [2:0]       state_q, state_d;
    logic [PTR_W:0]   init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [PTR_W:0]   len_q, len_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [ROW_W-1:0] head_row_q, head_row_d;
    logic [COL_W-1:0] head_col_q, head_col_d;
    logic [1:0]       dir_q, dir_d;
    logic             grow_pend_q, grow_pend_d;
    logic             step_grow_q, step_grow_d;
    logic [IDX_W-1:0] cand_q, cand_d;
    logic [ROW_W-1:0] cand_row_q, cand_row_d;
    logic [COL_W-1:0] cand_col_q, cand_col_d;
    logic [PTR_W:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0] scan_data_q;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] rd_data_q;
    logic             rd_valid_q;

    logic             wr_en;
    logic [PTR_W-1:0] wr_addr;
    logic [IDX_W-1:0] wr_data;
    logic [PTR_W-1:0] scan_addr;

    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_col;
    logic [IDX_W-1:0] nxt_idx;
    logic             hit_wall;
    logic             wall_kill;
    logic             step_grow_eff;
    logic             cmp_en;
    logic             self_hit;

    // Candidate head; at a wall the wrapped cell is produced and hit_wall flags the crossing.
    always_comb begin
        nxt_row  = head_row_q;
        nxt_col  = head_col_q;
        hit_wall = 1'b0;
        case (dir_q)
            DirUp: begin
                if (head_row_q == '0) begin
                    hit_wall = 1'b1;
                    nxt_row  = ROW_W'(GRID_H - 1);
                end else begin
                    nxt_row = head_row_q - ROW_W'(1);
                end
            end
            DirDown: begin
                if (head_row_q == ROW_W'(GRID_H - 1)) begin
                    hit_wall = 1'b1;
                    nxt_row  = '0;
                end else begin
                    nxt_row = head_row_q + ROW_W'(1);
                end
            end
            DirLeft: begin
                if (head_col_q == '0) begin
                    hit_wall = 1'b1;
                    nxt_col  = COL_W'(GRID_W - 1);
                end else begin
                    nxt_col = head_col_q - COL_W'(1);
                end
            end
            default: begin
                if (head_col_q == COL_W'(GRID_W - 1)) begin
                    hit_wall = 1'b1;
                    nxt_col  = '0;
                end else begin
                    nxt_col = head_col_q + COL_W'(1);
                end
            end
        endcase
        nxt_idx   = IDX_W'(nxt_row) * IDX_W'(GRID_W) + IDX_W'(nxt_col);
        wall_kill = hit_wall & ~WRAP_EN;
    end

    // The tail only stays put (and so can be hit) when this step really grows.
    assign step_grow_eff = step_grow_q && (len_q < LEN_MAX);
    assign scan_addr     = tail_q + scan_cnt_q[PTR_W-1:0];
    // scan_data_q holds entry scan_cnt_q-1; entry 0 is the tail.
    assign cmp_en   = (scan_cnt_q != '0) && ((scan_cnt_q != (PTR_W + 1)'(1)) || step_grow_eff);
    assign self_hit = cmp_en && (scan_data_q == cand_q);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        tail_d      = tail_q;
        head_ptr_d  = head_ptr_q;
        len_d       = len_q;
        head_d      = head_q;
        head_row_d  = head_row_q;
        head_col_d  = head_col_q;
        dir_d       = dir_q;
        step_grow_d = step_grow_q;
        cand_d      = cand_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        scan_cnt_d  = scan_cnt_q;
        done_d      = 1'b0;
        grow_pend_d = grow_pend_q | (iGrow && (state_q != StDead));
        overrun_d   = overrun_q | (iTick && (state_q != StIdle));
        wr_en       = 1'b0;
        wr_addr     = head_ptr_q + PTR_W'(1);
        wr_data     = cand_q;

        case (state_q)
            StInit: begin
                if (init_cnt_q == LEN_INIT) begin
                    len_d      = LEN_INIT;
                    head_ptr_d = PTR_W'(INIT_LEN - 1);
                    head_d     = START_IDX;
                    head_row_d = ROW_W'(START_ROW);
                    head_col_d = COL_W'(START_COL);
                    state_d    = StIdle;
                end else begin
                    wr_en      = 1'b1;
                    wr_addr    = init_cnt_q[PTR_W-1:0];
                    wr_data    = FIRST_IDX + IDX_W'(init_cnt_q);
                    init_cnt_d = init_cnt_q + (PTR_W + 1)'(1);
                end
            end
            StIdle: begin
                if (iTick) begin
                    // Exact reversal has all direction bits flipped.
                    if ((iDir ^ dir_q) != 2'b11) begin
                        dir_d = iDir;
                    end
                    state_d = StCalc;
                end
            end
            StCalc: begin
                cand_d      = nxt_idx;
                cand_row_d  = nxt_row;
                cand_col_d  = nxt_col;
                // Growth is claimed here so pulses during the scan arm the following step.
                step_grow_d = grow_pend_q | iGrow;
                grow_pend_d = 1'b0;
                scan_cnt_d  = '0;
                state_d     = wall_kill ? StDead : StScan;
            end
            StScan: begin
                if (self_hit) begin
                    state_d = StDead;
                end else if (scan_cnt_q == len_q) begin
                    state_d = StCommit;
                end else begin
                    scan_cnt_d = scan_cnt_q + (PTR_W + 1)'(1);
                end
            end
            StCommit: begin
                wr_en      = 1'b1;
                head_ptr_d = head_ptr_q + PTR_W'(1);
                head_d     = cand_q;
                head_row_d = cand_row_q;
                head_col_d = cand_col_q;
                done_d     = 1'b1;
                if (step_grow_eff) begin
                    len_d = len_q + (PTR_W + 1)'(1);
                end else begin
                    tail_d = tail_q + PTR_W'(1);
                end
                state_d = StIdle;
            end
            StDead: begin
                state_d = StDead;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= StInit;
            init_cnt_q  <= '0;
            tail_q      <= '0;
            head_ptr_q  <= '0;
            len_q       <= '0;
            head_q      <= '0;
            head_row_q  <= '0;
            head_col_q  <= '0;
            dir_q       <= DirRight;
            grow_pend_q <= 1'b0;
            step_grow_q <= 1'b0;
            cand_q      <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= '0;
            scan_cnt_q  <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            tail_q      <= tail_d;
            head_ptr_q  <= head_ptr_d;
            len_q       <= len_d;
            head_q      <= head_d;
            head_row_q  <= head_row_d;
            head_col_q  <= head_col_d;
            dir_q       <= dir_d;
            grow_pend_q <= grow_pend_d;
            step_grow_q <= step_grow_d;
            cand_q      <= cand_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            scan_cnt_q  <= scan_cnt_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge iCLK) begin
        scan_data_q <= mem_q[scan_addr];
    end

    // Renderer port: independent read, sees the RAM/tail as of the sampling edge.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= mem_q[tail_q + iRd_Idx];
            rd_valid_q <= (state_q != StInit) && ({1'b0, iRd_Idx} < len_q);
        end
    end

    assign oRd_Data  = rd_data_q;
    assign oRd_Valid = rd_valid_q;
    assign oLength   = len_q;
    assign oHead     = head_q;
    assign oBusy     = (state_q != StIdle);
    assign oDone     = done_q;
    assign oDead     = (state_q == StDead);
    assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_snake_body_writer.sv
// Directed bench for snake_body_writer: init contents, stepping, growth, reversal, overrun,
// wall handling (SNAKE_WRAP_EN aware), self-collision and tail exclusion.
module tb_snake_body_writer;

    typedef struct {
        logic [7:0]  idx;
        logic [11:0] data;
        logic        valid;
    } rd_vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  dir = 2'b01;
    logic        grow = 1'b0;
    logic [7:0]  rd_idx = 8'd0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic [8:0]  length;
    logic [11:0] head;
    logic        busy;
    logic        done;
    logic        dead;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snake_body_writer dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iTick     (tick),
        .iDir      (dir),
        .iGrow     (grow),
        .iRd_Idx   (rd_idx),
        .oRd_Data  (rd_data),
        .oRd_Valid (rd_valid),
        .oLength   (length),
        .oHead     (head),
        .oBusy     (busy),
        .oDone     (done),
        .oDead     (dead),
        .oOverrun  (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the read data is registered.
    task automatic rd(input logic [7:0] idx, output logic [11:0] d, output logic v);
        rd_idx = idx;
        @(negedge clk);
        d = rd_data;
        v = rd_valid;
    endtask

    // Issue one tick and count cycles until oDone; returns at the negedge oDone is seen.
    task automatic step(input logic [1:0] d, output int cyc);
        dir  = d;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc  = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic step_chk(input string name, input logic [1:0] d, input int exp_lat,
                            input logic [11:0] exp_head, input logic [8:0] exp_len);
        int cyc;
        step(d, cyc);
        check({name, " latency"}, cyc, exp_lat);
        check({name, " head"}, head, exp_head);
        check({name, " length"}, length, exp_len);
    endtask

    task automatic pulse_grow();
        grow = 1'b1;
        @(negedge clk);
        grow = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rd_vec_t     vecs[5];
        logic [11:0] d;
        logic        v;
        logic [11:0] exp_head;
        int          cyc;
        int          extra;

        vecs[0] = '{idx: 8'd0, data: 12'd1565, valid: 1'b1};
        vecs[1] = '{idx: 8'd1, data: 12'd1566, valid: 1'b1};
        vecs[2] = '{idx: 8'd2, data: 12'd1567, valid: 1'b1};
        vecs[3] = '{idx: 8'd3, data: 12'd1568, valid: 1'b1};
        vecs[4] = '{idx: 8'd4, data: 12'd0,    valid: 1'b0};

        repeat (2) @(negedge clk);
        check("rst length", length, 0);
        check("rst head", head, 0);
        check("rst busy", busy, 1);
        check("rst done", done, 0);
        check("rst dead", dead, 0);
        check("rst overrun", overrun, 0);
        check("rst rd_data", rd_data, 0);
        check("rst rd_valid", rd_valid, 0);

        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("init still busy", busy, 1);
        check("init length pending", length, 0);
        @(negedge clk);
        check("init length", length, 4);
        check("init head", head, 1568);
        check("init idle", busy, 0);

        for (int i = 0; i < 5; i++) begin
            rd(vecs[i].idx, d, v);
            check($sformatf("init rd valid idx%0d", vecs[i].idx), v, vecs[i].valid);
            if (vecs[i].valid) begin
                check($sformatf("init rd data idx%0d", vecs[i].idx), d, vecs[i].data);
            end
        end

        step_chk("right", 2'b01, 7, 12'd1569, 9'd4);
        @(negedge clk);
        check("done one cycle", done, 0);
        rd(8'd0, d, v);
        check("right rd idx0", d, 1566);
        rd(8'd3, d, v);
        check("right rd idx3", d, 1569);

        pulse_grow();
        step_chk("grow down", 2'b00, 7, 12'd1633, 9'd5);
        rd(8'd0, d, v);
        check("grow rd idx0", d, 1566);
        rd(8'd4, d, v);
        check("grow rd idx4", d, 1633);
        check("grow rd idx4 valid", v, 1);
        rd(8'd5, d, v);
        check("grow rd idx5 valid", v, 0);

        step_chk("right again", 2'b01, 8, 12'd1634, 9'd5);
        step_chk("reverse ignored", 2'b10, 8, 12'd1635, 9'd5);

        // Second tick lands while the first step is still scanning.
        dir  = 2'b01;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("overrun flag", overrun, 1);
        check("overrun head", head, 1636);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("overrun no extra step", extra, 0);
        check("overrun head held", head, 1636);

        exp_head = 12'd1636;
        for (int c = 36; c < 63; c++) begin
            exp_head = exp_head + 12'd1;
            step(2'b01, cyc);
            if (head !== exp_head || cyc != 8) begin
                check($sformatf("walk col%0d head", c + 1), head, exp_head);
                check($sformatf("walk col%0d latency", c + 1), cyc, 8);
            end
        end
        check("walk end head", head, 1663);

`ifdef SNAKE_WRAP_EN
        step_chk("wrap col", 2'b01, 8, 12'd1600, 9'd5);
        check("wrap alive", dead, 0);
`else
        dir  = 2'b01;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc   = 0;
        extra = 0;
        while (!dead && cyc < 50) begin
            @(negedge clk);
            if (done) extra++;
            cyc++;
        end
        check("wall dead", dead, 1);
        check("wall head held", head, 1663);
        check("wall no commit", extra, 0);
        check("wall busy", busy, 1);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("dead tick ignored", extra, 0);
        check("dead sticky", dead, 1);
`endif

        do_reset();
        check("reinit head", head, 1568);
        check("reinit dead clear", dead, 0);
        check("reinit overrun clear", overrun, 0);

        // Reset in the middle of a step must discard it.
        dir  = 2'b01;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midstep rst length", length, 0);
        check("midstep rst head", head, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midstep reinit head", head, 1568);
        check("midstep reinit length", length, 4);
        check("midstep no done", done, 0);

        // Length-4 loop: the cell re-entered is the tail, which vacates this step.
        step_chk("loop down", 2'b00, 7, 12'd1632, 9'd4);
        step_chk("loop left", 2'b10, 7, 12'd1631, 9'd4);
        step_chk("loop up onto tail", 2'b11, 7, 12'd1567, 9'd4);
        check("tail exclusion alive", dead, 0);
        rd(8'd0, d, v);
        check("loop rd tail", d, 1568);

        // Growing keeps the tail, so stepping onto it now kills.
        pulse_grow();
        dir  = 2'b01;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc   = 0;
        extra = 0;
        while (!dead && cyc < 50) begin
            @(negedge clk);
            if (done) extra++;
            cyc++;
        end
        check("grow tail collision dead", dead, 1);
        check("collision no commit", extra, 0);
        check("collision head held", head, 1567);
        check("collision length held", length, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
